// File: rtl/diffeq_operand_feeder.sv
// diffeq_operand_feeder: buffers whole jobs and replays them as one-hot nibble load strobes, then start/done.
// Optional DIFFEQ_FEED_CNT_EN adds a 16-bit jobs_issued counter of start pulses.
module diffeq_operand_feeder #(
    parameter int NIB_W = 4,
    parameter int GAP   = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             job_valid,
    output logic             job_ready,
    input  logic [NIB_W-1:0] job_x,
    input  logic [NIB_W-1:0] job_dx,
    input  logic [NIB_W-1:0] job_u,
    input  logic [NIB_W-1:0] job_a,
    output logic [NIB_W-1:0] in_nib,
    output logic             load_x,
    output logic             load_dx,
    output logic             load_a,
    output logic             load_u,
    output logic             start,
    input  logic             done,
`ifdef DIFFEQ_FEED_CNT_EN
    output logic [15:0]      jobs_issued,
`endif
    output logic             feed_idle
);
    typedef enum logic [2:0] {IDLE, LD_X, LD_DX, LD_A, LD_U, START, WAIT} state_t;
    localparam int JW = 4 * NIB_W;
    localparam logic [3:0] GAP4 = GAP[3:0];
    state_t state;
    logic [JW-1:0] mem [2];
    logic [JW-1:0] work, job_in, head;
    logic rd, wr, push, pop, first;
    logic [1:0] count, count_nxt;
    logic [3:0] cnt;
    logic [NIB_W-1:0] nib_sel;
`ifdef DIFFEQ_FEED_CNT_EN
    logic [15:0] issued;
    assign jobs_issued = issued;
`endif
    assign job_in    = {job_x, job_dx, job_u, job_a};
    assign push      = job_valid && job_ready;
    // an empty FIFO forwards the incoming job straight into the work register
    assign pop       = state == IDLE && (count != 2'd0 || push);
    assign head      = count == 2'd0 ? job_in : mem[rd];
    assign count_nxt = count + {1'b0, push} - {1'b0, pop};
    assign first     = cnt == GAP4;
    always_comb begin
        nib_sel = state == LD_X  ? work[4*NIB_W-1:3*NIB_W] :
                  state == LD_DX ? work[3*NIB_W-1:2*NIB_W] :
                  state == LD_A  ? work[NIB_W-1:0] :
                  state == LD_U  ? work[2*NIB_W-1:NIB_W] : '0;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            mem[0]    <= '0;
            mem[1]    <= '0;
            work      <= '0;
            rd        <= 1'b0;
            wr        <= 1'b0;
            count     <= 2'd0;
            cnt       <= 4'd0;
            job_ready <= 1'b0;
            feed_idle <= 1'b0;
            in_nib    <= '0;
            load_x    <= 1'b0;
            load_dx   <= 1'b0;
            load_a    <= 1'b0;
            load_u    <= 1'b0;
            start     <= 1'b0;
`ifdef DIFFEQ_FEED_CNT_EN
            issued    <= 16'd0;
`endif
        end else begin
            if (push) begin
                mem[wr] <= job_in;
                wr      <= ~wr;
            end
            if (pop) begin
                work <= head;
                rd   <= ~rd;
            end
            count     <= count_nxt;
            job_ready <= count_nxt != 2'd2;
            feed_idle <= state == IDLE && count == 2'd0;
            in_nib    <= first ? nib_sel : '0;
            load_x    <= state == LD_X && first;
            load_dx   <= state == LD_DX && first;
            load_a    <= state == LD_A && first;
            load_u    <= state == LD_U && first;
            start     <= state == START;
`ifdef DIFFEQ_FEED_CNT_EN
            if (state == START) issued <= issued + 16'd1;
`endif
            case (state)
                IDLE: if (pop) begin
                    state <= LD_X;
                    cnt   <= GAP4;
                end
                LD_X, LD_DX, LD_A, LD_U: if (cnt == 4'd0) begin
                    state <= state_t'(state + 3'd1);
                    cnt   <= GAP4;
                end else begin
                    cnt <= cnt - 4'd1;
                end
                START: state <= WAIT;
                WAIT: if (done) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
